fifo_burst_drain: RTL

Drain controller for an MLAB show-ahead FIFO: watches the FIFO fill level and empties it into an Avalon-MM burst write master in bursts of up to `burst_max` words. It triggers on a full burst's worth of data or on an age timeout for partial data. It sits between a producer-filled FIFO (write port owned elsewhere) and the memory-side interconnect, owning the FIFO read port and the write address pointer.

---
 rtl/fifo_burst_drain.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: drains a show-ahead FIFO into an Avalon-MM burst
// write master, on a full burst's worth of data or on an age timeout.
module fifo_burst_drain #(
    parameter int width      = 32,
    parameter int widthu     = 4,
    parameter int burst_max  = 8,
    parameter int addr_width = 30,
    parameter int timeout    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  addr_load,
    input  logic [addr_width-1:0] base_address,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic [widthu-1:0]     fifo_usedw,
    input  logic [width-1:0]      fifo_q,
    output logic                  fifo_rdreq,
    output logic [addr_width-1:0] avm_address,
    output logic                  avm_write,
    output logic [width-1:0]      avm_writedata,
    output logic [widthu:0]       avm_burstcount,
    input  logic                  avm_waitrequest,
    output logic                  busy
);

    localparam int age_w = $clog2(timeout + 1);
    localparam logic [widthu:0] burst_lim = burst_max[widthu:0];
    localparam logic [widthu:0] beat_one = 1;
    localparam logic [age_w-1:0] age_lim = timeout[age_w-1:0];
    localparam logic [age_w-1:0] age_one = 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    state_t                state_next;
    logic [widthu:0]       count;
    logic [widthu:0]       burst_len;
    logic [widthu:0]       beats_left;
    logic [age_w-1:0]      age;
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] load_addr;
    logic                  load_pend;
    logic                  start;
    logic                  accept;
    logic                  last_beat;

    // Full flag extends usedw, which wraps to 0 when the FIFO is full.
    assign count     = {fifo_full, fifo_usedw};
    assign burst_len = (count >= burst_lim) ? burst_lim : count;

    // fifo_empty stands in for count == 0 in the age/timeout terms.
    assign start = (state == IDLE) && enable &&
                   ((count >= burst_lim) ||
                    (!fifo_empty && age == age_lim));

    assign accept    = avm_write & ~avm_waitrequest;
    assign last_beat = accept && (beats_left == beat_one);

    assign fifo_rdreq    = accept;
    assign avm_address   = wr_ptr;
    assign avm_writedata = fifo_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: start a burst on trigger, return after the last beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BURST;
            BURST:   if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state.
    always_comb begin
        avm_write = 1'b0;
        busy      = 1'b0;
        if (state == BURST) begin
            avm_write = 1'b1;
            busy      = 1'b1;
        end
    end

    // Burst length is frozen at start; beats_left counts accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avm_burstcount <= '0;
            beats_left     <= '0;
        end else if (start) begin
            avm_burstcount <= burst_len;
            beats_left     <= burst_len;
        end else if (accept) begin
            beats_left <= beats_left - beat_one;
        end
    end

    // Age of partial data, saturating at the timeout value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (state == BURST || start || fifo_empty) begin
            age <= '0;
        end else if (count < burst_lim && age != age_lim) begin
            age <= age + age_one;
        end
    end

    // Write pointer: direct load in IDLE, deferred load during a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            load_addr <= '0;
            load_pend <= 1'b0;
        end else if (state == IDLE) begin
            if (addr_load) wr_ptr <= base_address;
        end else if (last_beat) begin
            load_pend <= 1'b0;
            if (addr_load)      wr_ptr <= base_address;
            else if (load_pend) wr_ptr <= load_addr;
            else wr_ptr <= wr_ptr + addr_width'(avm_burstcount);
        end else if (addr_load) begin
            load_pend <= 1'b1;
            load_addr <= base_address;
        end
    end

endmodule
